// File: rtl/mem_responder.sv
// Word-addressed memory target for the core's memory port. It uses a request/ready
// handshake, optional wait states and misaligned/out-of-range error reporting.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        memReq,
  input  logic [31:0] memAddr,
  input  logic        writeEn,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memReady,
  output logic        memErr
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e           state_q, state_d;
  logic [3:0]       waitCnt_q, waitCnt_d;
  logic [31:0]      reqAddr_q, reqData_q;
  logic             reqWe_q;
  logic [31:0]      readData_q;
  logic             memErr_q;
  logic             latchReq, doAccess;
  logic [31:0]      accAddr, accData;
  logic             accWe;
  logic             accBad;
  logic [IDX_W-1:0] accIdx;
  logic [31:0]      mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // With zero wait states the access uses the live request; otherwise it replays the latched one.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    latchReq  = 1'b0;
    doAccess  = 1'b0;
    accAddr   = reqAddr_q;
    accWe     = reqWe_q;
    accData   = reqData_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        state_d = ST_IDLE;
        if (memReq) begin
          latchReq = 1'b1;
          if (WAIT_CYCLES == 0) begin
            doAccess = 1'b1;
            accAddr  = memAddr;
            accWe    = writeEn;
            accData  = writeData;
            state_d  = ST_RESP;
          end else begin
            state_d   = ST_WAIT;
            waitCnt_d = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        waitCnt_d = waitCnt_q - 4'd1;
        if (waitCnt_q == 4'd1) begin
          doAccess = 1'b1;
          state_d  = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    memReady = (state_q == ST_RESP);
    readData = readData_q;
    memErr   = memErr_q;
  end

  always_comb begin
    accBad = (accAddr[1:0] != 2'b00)
          || ({1'b0, accAddr} < {1'b0, BASE_ADDR})
          || ({1'b0, accAddr} >= END_ADDR);
    accIdx = IDX_W'((accAddr - BASE_ADDR) >> 2);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      reqAddr_q <= '0;
      reqData_q <= '0;
      reqWe_q   <= 1'b0;
    end else if (latchReq) begin
      reqAddr_q <= memAddr;
      reqData_q <= writeData;
      reqWe_q   <= writeEn;
    end
  end

  // The array has no reset, so writes are gated while reset is held.
  always_ff @(posedge clk) begin
    if (rstN && doAccess && accWe && !accBad) begin
      mem[accIdx] <= accData;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      readData_q <= '0;
      memErr_q   <= 1'b0;
    end else if (doAccess) begin
      if (accBad) begin
        readData_q <= '0;
        memErr_q   <= 1'b1;
      end else begin
        readData_q <= accWe ? accData : mem[accIdx];
        memErr_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one zero-wait and one three-wait instance, checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_mem_responder;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk  = 1'b0;
  logic        rstN = 1'b0;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        we    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];

  int nChecks = 0;
  int nFails  = 0;
  int edgeN   = 0;

  int          lastAcc [2];
  bit          pend    [2];
  int          pendDue [2];
  logic [31:0] pAddr   [2];
  logic [31:0] pData   [2];
  bit          pWe     [2];
  logic [31:0] mm      [2][DEPTH];
  bit          known   [2][DEPTH];
  bit          eRdy    [2];
  bit          eErr    [2];
  bit          eKnown  [2];
  logic [31:0] eData   [2];

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rstN(rstN), .memReq(req[0]), .memAddr(addr[0]), .writeEn(we[0]),
    .writeData(wdata[0]), .readData(rdata[0]), .memReady(rdy[0]), .memErr(err[0]));

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3), .INIT_FILE("")) dut1 (
    .clk(clk), .rstN(rstN), .memReq(req[1]), .memAddr(addr[1]), .writeEn(we[1]),
    .writeData(wdata[1]), .readData(rdata[1]), .memReady(rdy[1]), .memErr(err[1]));

  always #5 clk = ~clk;

  function automatic int waitOf(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelAccess(input int d, input logic [31:0] a, input bit w, input logic [31:0] wd);
    longint unsigned la = a;
    int idx;
    eRdy[d] = 1'b1;
    if (a[1:0] != 2'b00 || la < longint'(BASE) || la >= longint'(BASE) + 4 * DEPTH) begin
      eErr[d] = 1'b1; eData[d] = 32'h0; eKnown[d] = 1'b1;
    end else begin
      idx = int'((la - longint'(BASE)) / 4);
      eErr[d] = 1'b0;
      if (w) begin
        mm[d][idx] = wd; known[d][idx] = 1'b1; eData[d] = wd; eKnown[d] = 1'b1;
      end else begin
        eData[d] = mm[d][idx]; eKnown[d] = known[d][idx];
      end
    end
  endtask

  // A request is accepted once the previous one has finished its wait period.
  task automatic modelStep(input int d);
    eRdy[d] = 1'b0;
    if (pend[d] && pendDue[d] == edgeN) begin
      pend[d] = 1'b0;
      modelAccess(d, pAddr[d], pWe[d], pData[d]);
    end
    if (req[d] && edgeN >= lastAcc[d] + waitOf(d) + 1) begin
      lastAcc[d] = edgeN;
      if (waitOf(d) == 0) modelAccess(d, addr[d], we[d], wdata[d]);
      else begin
        pend[d] = 1'b1; pendDue[d] = edgeN + waitOf(d);
        pAddr[d] = addr[d]; pWe[d] = we[d]; pData[d] = wdata[d];
      end
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      pend[d] = 1'b0; lastAcc[d] = -1000;
      eRdy[d] = 1'b0; eErr[d] = 1'b0; eData[d] = 32'h0; eKnown[d] = 1'b1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    edgeN++;
    if (rstN) begin
      modelStep(0);
      modelStep(1);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input bit r, input logic [31:0] a, input bit w,
                               input logic [31:0] wd);
    req[d] = r; addr[d] = a; we[d] = w; wdata[d] = wd;
    cyc();
  endtask

  task automatic idle(input int n);
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (n) cyc();
  endtask

  function automatic logic [31:0] randAddr();
    int          r    = $urandom_range(0, 9);
    logic [31:0] idx4 = 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (r < 7)  return BASE + idx4;
    if (r == 7) return BASE + idx4 + 32'($urandom_range(1, 3));
    if (r == 8) return BASE + 32'(4 * DEPTH) + idx4;
    return 32'hFFFF_FFFC;
  endfunction

  always @(negedge clk) begin
    if (rstN) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("memReady d%0d edge%0d", d, edgeN), 32'(rdy[d]), 32'(eRdy[d]));
        if (eRdy[d]) begin
          checkOutput($sformatf("memErr d%0d edge%0d", d, edgeN), 32'(err[d]), 32'(eErr[d]));
          if (eKnown[d])
            checkOutput($sformatf("readData d%0d edge%0d", d, edgeN), rdata[d], eData[d]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr[d] = 32'h0; we[d] = 1'b0; wdata[d] = 32'h0;
    end
    modelReset();
    repeat (3) cyc();
    checkOutput("reset memReady", 32'(rdy[0]), 32'h0);
    checkOutput("reset memErr", 32'(err[0]), 32'h0);
    checkOutput("reset readData", rdata[0], 32'h0);
    rstN = 1'b1;

    applyStimulus(0, 1'b1, 32'h0, 1'b1, 32'h0000_0013);
    applyStimulus(0, 1'b1, 32'h0, 1'b0, 32'h0);
    checkOutput("read word0 data", rdata[0], 32'h0000_0013);
    checkOutput("read word0 ready", 32'(rdy[0]), 32'h1);
    checkOutput("read word0 err", 32'(err[0]), 32'h0);

    req[0] = 1'b0;
    rstN = 1'b0;
    modelReset();
    #1;
    checkOutput("async reset memReady", 32'(rdy[0]), 32'h0);
    checkOutput("async reset memErr", 32'(err[0]), 32'h0);
    checkOutput("async reset readData", rdata[0], 32'h0);
    cyc();
    rstN = 1'b1;
    applyStimulus(0, 1'b1, 32'h0, 1'b0, 32'h0);
    checkOutput("word0 kept over reset", rdata[0], 32'h0000_0013);

    applyStimulus(0, 1'b1, 32'h10, 1'b1, 32'hDEAD_BEEF);
    checkOutput("b2b write data", rdata[0], 32'hDEAD_BEEF);
    checkOutput("b2b write ready", 32'(rdy[0]), 32'h1);
    applyStimulus(0, 1'b1, 32'h10, 1'b0, 32'h0);
    checkOutput("b2b read data", rdata[0], 32'hDEAD_BEEF);
    checkOutput("b2b read ready", 32'(rdy[0]), 32'h1);
    idle(1);
    checkOutput("b2b then idle", 32'(rdy[0]), 32'h0);

    applyStimulus(1, 1'b1, 32'h20, 1'b1, 32'hAAAA_5555);
    idle(4);
    applyStimulus(1, 1'b1, 32'h20, 1'b0, 32'h0);
    checkOutput("wait k ready", 32'(rdy[1]), 32'h0);
    applyStimulus(1, 1'b1, 32'h10, 1'b0, 32'h0);
    checkOutput("wait k+1 ready", 32'(rdy[1]), 32'h0);
    applyStimulus(1, 1'b1, 32'h10, 1'b1, 32'h5151_5151);
    checkOutput("wait k+2 ready", 32'(rdy[1]), 32'h0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wait k+3 ready", 32'(rdy[1]), 32'h1);
    checkOutput("wait k+3 data", rdata[1], 32'hAAAA_5555);
    idle(1);
    checkOutput("wait no extra response", 32'(rdy[1]), 32'h0);
    idle(3);

    applyStimulus(0, 1'b1, 32'h12, 1'b1, 32'hCAFE_F00D);
    checkOutput("misaligned err", 32'(err[0]), 32'h1);
    checkOutput("misaligned data", rdata[0], 32'h0);
    applyStimulus(0, 1'b1, 32'h10, 1'b0, 32'h0);
    checkOutput("word 0x10 unchanged", rdata[0], 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, BASE + 32'(4 * DEPTH), 1'b0, 32'h0);
    checkOutput("out of range err", 32'(err[0]), 32'h1);
    checkOutput("out of range data", rdata[0], 32'h0);
    idle(1);

    applyStimulus(1, 1'b1, 32'h20, 1'b1, 32'h1234_5678);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 32'h0);
    rstN = 1'b0;
    modelReset();
    #2;
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checkOutput("no response after reset", 32'(rdy[1]), 32'h0);
    end
    applyStimulus(1, 1'b1, 32'h20, 1'b0, 32'h0);
    idle(3);
    checkOutput("aborted write not committed", rdata[1], 32'hAAAA_5555);
    idle(1);

    applyStimulus(0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), 1'b1, 32'h0BAD_F00D);
    checkOutput("last word write err", 32'(err[0]), 32'h0);
    applyStimulus(0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), 1'b0, 32'h0);
    checkOutput("last word read data", rdata[0], 32'h0BAD_F00D);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("resp to idle", 32'(rdy[0]), 32'h0);

    repeat (400) begin
      for (int d = 0; d < 2; d++) begin
        req[d]   = ($urandom_range(0, 2) != 0);
        addr[d]  = randAddr();
        we[d]    = $urandom_range(0, 1) == 1;
        wdata[d] = $urandom;
      end
      cyc();
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
